// File: rtl/vf_linear_array_if.sv
// Stream and configuration bundle for vf_linear_array.
// The slave modport is the array itself; the master modport is the
// stream source, stream sink and register bank side.
interface vf_linear_array_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 48,
    parameter int ADDR_W = 4
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_x;
    logic signed [ACC_W-1:0]  in_acc;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_x;
    logic signed [ACC_W-1:0]  out_acc;
    logic                     cfg_we;
    logic [ADDR_W-1:0]        cfg_addr;
    logic [31:0]              cfg_data;
    logic                     cfg_commit;
    logic                     cfg_busy;

    modport master (
        output in_valid, in_x, in_acc, out_ready,
        output cfg_we, cfg_addr, cfg_data, cfg_commit,
        input  in_ready, out_valid, out_x, out_acc, cfg_busy
    );

    modport slave (
        input  in_valid, in_x, in_acc, out_ready,
        input  cfg_we, cfg_addr, cfg_data, cfg_commit,
        output in_ready, out_valid, out_x, out_acc, cfg_busy
    );
endinterface

// File: rtl/vf_linear_array.sv
// Linear chain of NUM_PE arithmetic PEs with a systolic x/acc datapath,
// valid/ready streaming and double-buffered per-PE configuration.
//
// Commit FSM:
//   state   | meaning
//   ST_IDLE | active config in use, no commit requested
//   ST_PEND | commit requested; input blocked until the pipe drains,
//           | then shadow is copied to active
module vf_linear_array #(
    parameter int NUM_PE = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 48,
    parameter int ADDR_W = 4
) (
    input logic               clk,
    input logic               rst_n,
    vf_linear_array_if.slave  bus
);

    typedef struct packed {
        logic [3:0]        op;
        logic              bypass;
        logic              sat;
        logic [DATA_W-1:0] coeff;
    } pe_cfg_t;

    typedef enum logic {ST_IDLE, ST_PEND} cstate_t;

    pe_cfg_t shadow_q [NUM_PE];
    pe_cfg_t active_q [NUM_PE];
    pe_cfg_t cfg_new;

    logic                     vld_q [NUM_PE];
    logic signed [DATA_W-1:0] x_q   [NUM_PE];
    logic signed [ACC_W-1:0]  acc_q [NUM_PE];
    logic                     vld_d [NUM_PE];
    logic signed [DATA_W-1:0] x_d   [NUM_PE];
    logic signed [ACC_W-1:0]  acc_d [NUM_PE];

    cstate_t state_q, state_d;
    logic    commit_fire;
    logic    pipe_busy;
    logic    advance;
    logic    accept;
    logic    unused_cfg_bits;

    // Result is formed one bit wider than the lane so a single guard bit
    // exposes overflow for the saturating mode.
    function automatic logic [ACC_W-1:0] pe_acc(input pe_cfg_t c,
                                                 input logic signed [DATA_W-1:0] x,
                                                 input logic signed [ACC_W-1:0] a);
        logic signed [2*DATA_W-1:0] p;
        logic signed [ACC_W:0]      ae, pe, xe, r;
        p  = x * $signed(c.coeff);
        ae = (ACC_W+1)'(a);
        pe = (ACC_W+1)'(p);
        xe = (ACC_W+1)'(x);
        case (c.op)
            4'd1:    r = pe;
            4'd2:    r = ae + pe;
            4'd3:    r = ae + xe;
            4'd4:    r = ae - xe;
            4'd5:    r = ae - pe;
            4'd6:    r = xe;
            4'd7:    r = '0;
            default: r = ae;
        endcase
        if (c.bypass) r = ae;
        if (c.sat && (r[ACC_W] != r[ACC_W-1]))
            return r[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return r[ACC_W-1:0];
    endfunction

    assign advance          = ~vld_q[NUM_PE-1] | bus.out_ready;
    assign bus.cfg_busy     = (state_q == ST_PEND);
    assign bus.in_ready     = advance & ~bus.cfg_busy & ~bus.cfg_commit;
    assign accept           = bus.in_valid & bus.in_ready;
    assign bus.out_valid    = vld_q[NUM_PE-1];
    assign bus.out_x        = x_q[NUM_PE-1];
    assign bus.out_acc      = acc_q[NUM_PE-1];

    // Coefficient field is 16 bits wide; sign-extend or truncate to the lane.
    assign cfg_new.op       = bus.cfg_data[3:0];
    assign cfg_new.bypass   = bus.cfg_data[4];
    assign cfg_new.sat      = bus.cfg_data[5];
    assign cfg_new.coeff    = DATA_W'($signed(bus.cfg_data[31:16]));
    assign unused_cfg_bits  = ^bus.cfg_data[15:6];

    for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
        if (k == 0) begin : g_head
            assign vld_d[k] = accept;
            assign x_d[k]   = bus.in_x;
            assign acc_d[k] = pe_acc(active_q[k], bus.in_x, bus.in_acc);
        end else begin : g_tail
            assign vld_d[k] = vld_q[k-1];
            assign x_d[k]   = x_q[k-1];
            assign acc_d[k] = pe_acc(active_q[k], x_q[k-1], acc_q[k-1]);
        end
    end

    // Any beat anywhere in the chain, including the output stage.
    always_comb begin
        pipe_busy = 1'b0;
        for (int k = 0; k < NUM_PE; k++) pipe_busy = pipe_busy | vld_q[k];
    end

    // All stages shift together on advance; bubbles are kept in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PE; k++) begin
                vld_q[k] <= 1'b0;
                x_q[k]   <= '0;
                acc_q[k] <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < NUM_PE; k++) begin
                vld_q[k] <= vld_d[k];
                x_q[k]   <= x_d[k];
                acc_q[k] <= acc_d[k];
            end
        end
    end

    // Shadow takes writes at any time; active only changes on an empty pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PE; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_PE; k++) begin
                if (bus.cfg_we && (bus.cfg_addr == ADDR_W'(k))) shadow_q[k] <= cfg_new;
                if (commit_fire) active_q[k] <= shadow_q[k];
            end
        end
    end

    // Commit state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Commit next-state: request latches, copy waits for a fully drained pipe.
    always_comb begin
        state_d     = state_q;
        commit_fire = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.cfg_commit) state_d = ST_PEND;
            ST_PEND: if (!pipe_busy) begin
                commit_fire = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_vf_linear_array.sv
// Bench for vf_linear_array: directed scenarios with literal expectations
// plus randomized traffic, all checked against a transaction-level model.
module tb_vf_linear_array;
    localparam int NUM_PE = 4;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 48;
    localparam int ADDR_W = 4;
    localparam longint ACC_MAX = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W-1));
    localparam longint ACC_MOD = longint'(1) <<< ACC_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vf_linear_array_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) bus ();

    vf_linear_array #(.NUM_PE(NUM_PE), .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        longint x;
        longint acc;
        int     rem;
    } beat_t;

    beat_t       mq[$];
    logic [31:0] sh_cfg [NUM_PE];
    logic [31:0] act_cfg [NUM_PE];
    bit          m_pend;
    longint      got_x[$];
    longint      got_acc[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          out_mode = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cfgw(input int op, input bit byp, input bit sat, input int coeff);
        logic [15:0] c;
        logic [3:0]  o;
        c = 16'(coeff);
        o = 4'(op);
        return {c, 10'b0, sat, byp, o};
    endfunction

    function automatic longint wrap(input longint v);
        longint w;
        w = v;
        while (w > ACC_MAX) w -= ACC_MOD;
        while (w < ACC_MIN) w += ACC_MOD;
        return w;
    endfunction

    function automatic longint pe_step(input logic [31:0] c, input longint x, input longint acc);
        longint coeff, p, r;
        coeff = longint'($signed(c[31:16]));
        p = x * coeff;
        if (c[4]) return acc;
        case (int'(c[3:0]))
            1:       r = p;
            2:       r = acc + p;
            3:       r = acc + x;
            4:       r = acc - x;
            5:       r = acc - p;
            6:       r = x;
            7:       r = 0;
            default: r = acc;
        endcase
        if (c[5]) r = (r > ACC_MAX) ? ACC_MAX : ((r < ACC_MIN) ? ACC_MIN : r);
        else      r = wrap(r);
        return r;
    endfunction

    function automatic longint chain(input longint x, input longint acc);
        longint a;
        a = acc;
        for (int k = 0; k < NUM_PE; k++) a = pe_step(act_cfg[k], x, a);
        return a;
    endfunction

    function automatic bit exp_ov();
        return (mq.size() > 0) && (mq[0].rem == 0);
    endfunction

    // Transaction-level model: each accepted beat carries a count of
    // advancing edges still needed before it reaches the output.
    initial begin
        bit    ov, adv, acc_ok, empty;
        beat_t b;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_pend = 1'b0;
                for (int k = 0; k < NUM_PE; k++) begin
                    sh_cfg[k]  = '0;
                    act_cfg[k] = '0;
                end
            end else begin
                ov     = exp_ov();
                adv    = !ov || bus.out_ready;
                acc_ok = bus.in_valid && adv && !m_pend && !bus.cfg_commit;
                empty  = (mq.size() == 0);
                if (adv) begin
                    if (ov) begin
                        got_x.push_back(longint'($signed(bus.out_x)));
                        got_acc.push_back(longint'($signed(bus.out_acc)));
                        void'(mq.pop_front());
                    end
                    for (int i = 0; i < mq.size(); i++) mq[i].rem = mq[i].rem - 1;
                    if (acc_ok) begin
                        b.x   = longint'($signed(bus.in_x));
                        b.acc = chain(b.x, longint'($signed(bus.in_acc)));
                        b.rem = NUM_PE - 1;
                        mq.push_back(b);
                    end
                end
                if (m_pend && empty) begin
                    act_cfg = sh_cfg;
                    m_pend  = 1'b0;
                end else if (!m_pend && bus.cfg_commit) begin
                    m_pend = 1'b1;
                end
                if (bus.cfg_we && int'(bus.cfg_addr) < NUM_PE) sh_cfg[int'(bus.cfg_addr)] = bus.cfg_data;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        bit ov;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                ov = exp_ov();
                chk("out_valid", longint'(bus.out_valid), longint'(ov));
                chk("cfg_busy", longint'(bus.cfg_busy), longint'(m_pend));
                chk("in_ready", longint'(bus.in_ready),
                    longint'((!ov || bus.out_ready) && !m_pend && !bus.cfg_commit));
                if (ov) begin
                    chk("out_x", longint'($signed(bus.out_x)), mq[0].x);
                    chk("out_acc", longint'($signed(bus.out_acc)), mq[0].acc);
                end
            end
        end
    end

    // Sink: always ready, random, or stalled.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (out_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input longint x, input longint acc);
        bit took;
        int lim;
        took = 1'b0;
        lim  = 0;
        bus.in_valid = 1'b1;
        bus.in_x     = DATA_W'(x);
        bus.in_acc   = ACC_W'(acc);
        while (!took && lim < 500) begin
            @(negedge clk);
            took = bus.in_ready;
            step();
            lim++;
        end
        bus.in_valid = 1'b0;
        chk("send_accept", longint'(took), 1);
    endtask

    task automatic cfg_write(input int addr, input logic [31:0] word);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = ADDR_W'(addr);
        bus.cfg_data = word;
        step();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic commit_wait();
        int lim;
        lim = 0;
        bus.cfg_commit = 1'b1;
        step();
        bus.cfg_commit = 1'b0;
        while (bus.cfg_busy && lim < 1000) begin
            step();
            lim++;
        end
        chk("commit_done", longint'(bus.cfg_busy), 0);
    endtask

    task automatic drain();
        int lim;
        lim = 0;
        while (mq.size() != 0 && lim < 2000) begin
            step();
            lim++;
        end
        chk("drain", longint'(mq.size()), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base, n, r;
        logic [47:0] ra;
        bus.in_valid   = 1'b0;
        bus.in_x       = '0;
        bus.in_acc     = '0;
        bus.cfg_we     = 1'b0;
        bus.cfg_addr   = '0;
        bus.cfg_data   = '0;
        bus.cfg_commit = 1'b0;

        // Model sanity against hand arithmetic.
        chk("model_mac", pe_step(cfgw(2, 0, 0, 3), 2, 5), 11);
        chk("model_sat", pe_step(cfgw(3, 0, 1, 0), 1, ACC_MAX), ACC_MAX);
        chk("model_wrap", pe_step(cfgw(3, 0, 0, 0), 1, ACC_MAX), ACC_MIN);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_out_x", longint'($signed(bus.out_x)), 0);
        chk("rst_out_acc", longint'($signed(bus.out_acc)), 0);
        chk("rst_cfg_busy", longint'(bus.cfg_busy), 0);
        step();
        rst_n = 1'b1;
        step();

        // PASS chain and latency.
        base = got_acc.size();
        send(5, 7);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        chk("pass_latency", n, NUM_PE - 1);
        drain();
        chk("pass_x", got_x[base], 5);
        chk("pass_acc", got_acc[base], 7);

        // FIR coefficients 1..4.
        for (int k = 0; k < NUM_PE; k++) cfg_write(k, cfgw(2, 0, 0, k + 1));
        commit_wait();
        base = got_acc.size();
        repeat (4) send(1, 0);
        send(-2, 0);
        drain();
        for (int i = 0; i < 4; i++) chk("fir_ones", got_acc[base+i], 10);
        chk("fir_neg", got_acc[base+4], -20);

        // Backpressure mid-stream.
        base = got_acc.size();
        fork
            begin
                for (int i = 0; i < 8; i++) send(i + 10, i * 100);
            end
            begin
                repeat (4) step();
                out_mode = 2;
                repeat (5) step();
                out_mode = 0;
            end
        join
        drain();
        chk("bp_count", got_acc.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            chk("bp_order_x", got_x[base+i], i + 10);
            chk("bp_acc", got_acc[base+i], (i + 10) * 10 + i * 100);
        end

        // Commit while beats are in flight.
        base = got_acc.size();
        repeat (3) send(1, 0);
        bus.cfg_we     = 1'b1;
        bus.cfg_addr   = ADDR_W'(1);
        bus.cfg_data   = cfgw(4, 0, 0, 0);
        bus.cfg_commit = 1'b1;
        step();
        bus.cfg_we     = 1'b0;
        bus.cfg_commit = 1'b0;
        chk("busy_set", longint'(bus.cfg_busy), 1);
        n = 0;
        while (bus.cfg_busy && n < 100) begin
            step();
            n++;
        end
        chk("busy_clear", longint'(bus.cfg_busy), 0);
        send(3, 0);
        drain();
        for (int i = 0; i < 3; i++) chk("old_cfg_beat", got_acc[base+i], 10);
        chk("new_cfg_sub", got_acc[base+3], 21);

        // Saturating and wrapping ADD.
        cfg_write(0, cfgw(3, 0, 1, 0));
        for (int k = 1; k < NUM_PE; k++) cfg_write(k, cfgw(0, 0, 0, 0));
        commit_wait();
        base = got_acc.size();
        send(1, ACC_MAX);
        cfg_write(0, cfgw(3, 0, 0, 0));
        commit_wait();
        send(1, ACC_MAX);
        drain();
        chk("sat_clamp", got_acc[base], ACC_MAX);
        chk("sat_wrap", got_acc[base+1], ACC_MIN);

        // Bypass overrides CLR; out-of-range address is ignored.
        cfg_write(0, cfgw(0, 0, 0, 0));
        cfg_write(2, cfgw(7, 1, 0, 0));
        commit_wait();
        base = got_acc.size();
        send(9, 123);
        cfg_write(NUM_PE, cfgw(7, 0, 0, 0));
        commit_wait();
        send(9, 55);
        drain();
        chk("bypass_clr", got_acc[base], 123);
        chk("addr_oob", got_acc[base+1], 55);

        // Randomized traffic, config writes and commits.
        out_mode = 1;
        repeat (400) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                ra = 48'({$urandom, $urandom});
                send(longint'($signed(16'($urandom))), longint'($signed(ra)));
            end else if (r < 80) begin
                step();
            end else if (r < 93) begin
                cfg_write($urandom_range(0, NUM_PE),
                          cfgw($urandom_range(0, 15), ($urandom_range(0, 7) == 0),
                               $urandom_range(0, 1), int'($urandom_range(0, 65535))));
            end else begin
                bus.cfg_commit = 1'b1;
                step();
                bus.cfg_commit = 1'b0;
            end
        end
        drain();
        out_mode = 0;
        step();

        // Async reset with a stalled pipe and a pending commit.
        out_mode = 2;
        repeat (4) send(1, 1);
        bus.cfg_commit = 1'b1;
        step();
        bus.cfg_commit = 1'b0;
        chk("pre_rst_valid", longint'(bus.out_valid), 1);
        chk("pre_rst_busy", longint'(bus.cfg_busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", longint'(bus.out_valid), 0);
        chk("async_rst_busy", longint'(bus.cfg_busy), 0);
        chk("async_rst_acc", longint'($signed(bus.out_acc)), 0);
        out_mode = 0;
        step();
        rst_n = 1'b1;
        step();
        base = got_acc.size();
        send(4, 11);
        drain();
        chk("post_rst_x", got_x[base], 4);
        chk("post_rst_acc", got_acc[base], 11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
